// File: rtl/hazard_ctrl.sv
// Load-use interlock and ALU operand forwarding controller for a 5-stage pipeline.
// A shadow copy of the EX/MEM/WB destination fields drives hazard detection and forwarding.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_wen,
    input  logic             id_load,
    input  logic             flush,
    input  logic             mem_hold,
    output logic             pc_hold,
    output logic             ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       wen;
        logic       load;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;

    logic             lu_stall;
    logic             issue;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Register 0 is hard-wired, so a stage never "produces" it.
    function automatic logic writes(input stage_t s, input logic [4:0] r);
        return s.valid && s.wen && (s.dst == r) && (r != 5'd0);
    endfunction

    always_comb begin
        lu_stall  = id_valid && ex_q.load &&
                    ((writes(ex_q, id_rs) && id_uses_rs) ||
                     (writes(ex_q, id_rt) && id_uses_rt));
        pc_hold   = mem_hold || (lu_stall && !flush);
        ex_bubble = !mem_hold && (flush || lu_stall || !id_valid);
        issue     = !ex_bubble && !mem_hold;
    end

    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.dst   = id_dst;
            ex_d.wen   = id_wen;
            ex_d.load  = id_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_hold) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // The load flag only matters while the producer sits in EX.
    logic unused_load;
    assign unused_load = mem_q.load ^ wb_q.load;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [4:0] src;
            logic       use_src;
            logic [1:0] fwd_q, fwd_d;

            assign src     = (gi == 0) ? id_rs : id_rt;
            assign use_src = (gi == 0) ? id_uses_rs : id_uses_rt;

            // Nearest producer wins; EX cannot hold a load here since that case stalls.
            always_comb begin
                fwd_d = 2'b00;
                if (issue && use_src) begin
                    if (writes(ex_q, src))       fwd_d = 2'b01;
                    else if (writes(mem_q, src)) fwd_d = 2'b10;
                    else if (writes(wb_q, src))  fwd_d = 2'b11;
                end
            end

            always_ff @(posedge clk) begin
                if (rst)            fwd_q <= 2'b00;
                else if (!mem_hold) fwd_q <= fwd_d;
            end
        end
    endgenerate

    assign fwd_a = g_fwd[0].fwd_q;
    assign fwd_b = g_fwd[1].fwd_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (lu_stall && !flush && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)            stall_cnt_q <= '0;
        else if (!mem_hold) stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: registered expectations go through a scoreboard queue,
// combinational hold/bubble outputs are checked in the same cycle they are driven.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_uses_rs, id_uses_rt, id_wen, id_load, flush, mem_hold;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        pc_hold, ex_bubble, pc_hold_s, ex_bubble_s;
    logic [1:0]  fwd_a, fwd_b, fwd_a_s, fwd_b_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;

    int checks   = 0;
    int failures = 0;
    int step     = 0;
    int cnt      = 0;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .mem_hold(mem_hold), .pc_hold(pc_hold),
        .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used to observe saturation.
    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_load(id_load), .flush(flush), .mem_hold(mem_hold), .pc_hold(pc_hold_s),
        .ex_bubble(ex_bubble_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL step %0d %s observed=%0h expected=%0h", step, tag, got, exp);
        end
    endtask

    task automatic ins(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input logic [4:0] dst,
                       input bit wen, input bit ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_wen = wen; id_load = ld;
    endtask

    // cc bit0: check pc_hold, bit1: check ex_bubble; ecnt is the expected count after the edge.
    task automatic cyc(input bit fl, input bit mh, input bit r, input bit [1:0] cc,
                       input bit eph, input bit ebub, input logic [1:0] efa,
                       input logic [1:0] efb, input int ecnt);
        exp_t e;
        flush = fl; mem_hold = mh; rst = r;
        #1;
        if (cc[0]) begin
            chk("pc_hold", {15'd0, pc_hold}, {15'd0, eph});
            chk("pc_hold_sat", {15'd0, pc_hold_s}, {15'd0, eph});
        end
        if (cc[1]) chk("ex_bubble", {15'd0, ex_bubble}, {15'd0, ebub});
        sb.push_back('{fa: efa, fb: efb, cnt: ecnt[15:0]});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("fwd_a", {14'd0, fwd_a}, {14'd0, e.fa});
        chk("fwd_b", {14'd0, fwd_b}, {14'd0, e.fb});
        chk("stall_cnt", stall_cnt, e.cnt);
        chk("stall_cnt_sat", {14'd0, stall_cnt_s}, (e.cnt > 16'd3) ? 16'd3 : e.cnt);
        $display("step %0d rst=%0b flush=%0b hold=%0b pc_hold=%0b bubble=%0b fwd_a=%0d fwd_b=%0d cnt=%0d sat=%0d",
                 step, r, fl, mh, eph, ebub, fwd_a, fwd_b, stall_cnt, stall_cnt_s);
        step++;
    endtask

    initial begin
        // Reset with random decode inputs.
        for (int i = 0; i < 2; i++) begin
            ins($urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom_range(0, 1),
                $urandom_range(0, 1), 5'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
            cyc($urandom_range(0, 1), 1'b0, 1'b1, (i == 1) ? 2'b01 : 2'b00, 0, 0, 2'b00, 2'b00, 0);
        end

        // Back-to-back ALU dependencies on r3, then nearest-producer priority.
        ins(1, 1, 2, 1, 1, 3, 1, 0);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 3, 4, 1, 1, 6, 1, 0);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b00, 0);
        ins(1, 7, 3, 1, 1, 8, 1, 0);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b10, 0);
        ins(1, 3, 3, 0, 1, 9, 1, 0);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b11, 0);
        ins(1, 3, 3, 1, 1, 10, 1, 0);  cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 10, 9, 1, 1, 11, 1, 0); cyc(0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b10, 0);

        // Load-use on r5: one stall cycle, then the consumer issues.
        ins(1, 1, 2, 1, 1, 5, 1, 1);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 11, 5, 1, 1, 12, 1, 0); cyc(0, 0, 0, 2'b11, 1, 1, 2'b00, 2'b00, 1);
        cnt = 1;
        cyc(0, 0, 0, 2'b11, 0, 0, 2'b11, 2'b10, cnt);

        // Register zero never forwards and never stalls.
        ins(1, 1, 1, 1, 1, 0, 1, 0);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
        ins(1, 0, 12, 1, 1, 13, 1, 0); cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b10, cnt);
        ins(1, 0, 0, 1, 1, 0, 1, 1);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
        ins(1, 0, 13, 1, 1, 14, 1, 0); cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b10, cnt);

        // Flush beats a load-use stall; EX must become a bubble.
        ins(1, 0, 0, 0, 0, 7, 1, 1);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
        ins(1, 7, 14, 1, 1, 15, 1, 0); cyc(1, 0, 0, 2'b11, 0, 1, 2'b00, 2'b00, cnt);
        cyc(0, 0, 0, 2'b11, 0, 0, 2'b10, 2'b11, cnt);

        // Three-cycle memory hold freezes everything.
        ins(1, 15, 7, 1, 1, 16, 1, 0); cyc(0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b11, cnt);
        ins(1, 16, 15, 1, 1, 17, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 2'b11, 1, 0, 2'b01, 2'b11, cnt);
        cyc(0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b10, cnt);

        // Hold overlapping a load-use: no count until the hold releases.
        ins(1, 0, 0, 0, 0, 20, 1, 1);  cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
        ins(1, 20, 16, 1, 1, 21, 1, 0); cyc(0, 1, 0, 2'b11, 1, 0, 2'b00, 2'b00, cnt);
        cnt++;
        cyc(0, 0, 0, 2'b11, 1, 1, 2'b00, 2'b00, cnt);
        cyc(0, 0, 0, 2'b11, 0, 0, 2'b10, 2'b00, cnt);

        // Invalid decode slot inserts a bubble.
        ins(0, 21, 21, 1, 1, 22, 1, 0); cyc(0, 0, 0, 2'b11, 0, 1, 2'b00, 2'b00, cnt);

        // Four more load-use stalls push the narrow counter into saturation.
        for (int i = 0; i < 4; i++) begin
            ins(1, 0, 0, 0, 0, 25, 1, 1);  cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
            ins(1, 0, 25, 0, 1, 26, 1, 0);
            cnt++;
            cyc(0, 0, 0, 2'b11, 1, 1, 2'b00, 2'b00, cnt);
            cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b10, cnt);
        end

        // Mid-operation reset drops a pending load, so the consumer does not stall.
        ins(1, 0, 0, 0, 0, 9, 1, 1);   cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, cnt);
        ins(1, 9, 9, 1, 1, 10, 1, 0);  cyc(0, 0, 1, 2'b00, 0, 0, 2'b00, 2'b00, 0);
        cyc(0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Interlock and forwarding controller for the 5-stage CPU pipeline. Sits beside the decode stage.
- Tracks the destination registers of in-flight instructions in EX, MEM and WB using an internal shadow pipeline.
- Detects load-use hazards and generates PC/IF-ID hold and ID/EX bubble controls.
- Produces registered forwarding selects for the ALU operands. These are valid during the instruction's EX cycle.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs  in  5  source register A of decode instruction
- id_rt  in  5  source register B of decode instruction
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_dst  in  5  destination selected by decode (rt, rd or 31)
- id_wen  in  1  instruction writes the register file
- id_load  in  1  instruction is a load (result available after MEM)
- flush  in  1  branch/jump redirect; squash the decode instruction
- mem_hold  in  1  data memory not ready; freeze the whole pipeline
- pc_hold  out  1  freeze PC and the IF/ID register (combinational)
- ex_bubble  out  1  load a bubble into ID/EX (combinational)
- fwd_a  out  2  operand A select in EX: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB write-through
- fwd_b  out  2  operand B select, same encoding
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Shadow stages ex, mem, wb each hold the fields valid, dst, wen and load.
- A stage "writes r" when all of the following hold: valid=1, wen=1, dst=r, r!=0. Register 0 never matches.
- lu_stall = id_valid & (ex writes id_rs & id_uses_rs | ex writes id_rt & id_uses_rt) & ex.load.
- pc_hold = mem_hold | (lu_stall & ~flush).
- ex_bubble = ~mem_hold & (flush | lu_stall | ~id_valid).
- issue = ~ex_bubble & ~mem_hold.
- Rising clk, rst=1: all valid bits 0, dst 0, fwd_a=fwd_b=00, stall_cnt=0. Reset mid-operation discards all tracked state in one cycle.
- Rising clk, mem_hold=1: every register holds, including the fwd outputs and stall_cnt.
- Rising clk otherwise (shadow stages):
  - wb <= mem, mem <= ex.
  - ex <= the decode fields when issue=1, else a bubble (valid=0).
- Rising clk otherwise (forwarding, operand A; operand B identical using id_rt/id_uses_rt):
  - If issue=0, or id_uses_rs=0: fwd_a <= 00.
  - Else nearest producer wins:
    - ex writes id_rs -> 01
    - else mem writes id_rs -> 10
    - else wb writes id_rs -> 11
    - else 00
  - ex is never a load when issue=1, because that case stalls.
- Rising clk otherwise (counter): stall_cnt increments when lu_stall & ~flush, and saturates at all-ones.
- Simultaneous flush and lu_stall: flush wins. A bubble is inserted, pc_hold=0, and there is no stall count.
- A load-use stall lasts exactly one cycle. The load then moves to mem and the consumer issues with select 10.
- Forward selects and shadow state are fully determined by the sequence of clk edges. There is no combinational path from id_* to fwd_*.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> pc_hold=0 (when mem_hold=0), fwd_a=fwd_b=00, stall_cnt=0.
- Back-to-back ALU dependency: issue add r3 (dst 3), then sub reading rs=3 -> in sub's EX cycle fwd_a=01. A third instruction reading rt=3 gets fwd_b=10. A fourth gets fwd_b=11. A fifth gets 00.
- Load-use: issue lw dst 5, then an instruction reading rt=5:
  - First cycle: pc_hold=1, ex_bubble=1, stall_cnt 0->1.
  - Next cycle: pc_hold=0, and the consumer issues with fwd_b=10.
- Register zero: a producer with dst 0 and wen=1, followed by a consumer with rs=0 -> fwd_a=00. A load to r0 followed by a use of r0 -> no stall.
- Flush priority: a load-use condition with flush=1 in the same cycle -> pc_hold=0, ex_bubble=1, stall_cnt unchanged, and ex becomes a bubble.
- mem_hold: assert for 3 cycles mid-sequence -> pc_hold=1, ex_bubble=0, and fwd/stall_cnt/shadow state frozen. After release, forwarding resumes exactly as if the hold never happened.
- Saturation: set CNT_W=2 and cause 5 load-use stalls -> stall_cnt reads 3.
